// File: rtl/phs_axil_pkg.sv
// Shared types and constants for the two-port PHS AXI4-Lite arbiter.
package phs_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  // Requester index: 0 = port S0, 1 = port S1.
  typedef logic port_idx_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] port_onehot(input port_idx_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/phs_rr_arbiter.sv
// Two-way round-robin pick. On a tie the port that was not served last wins;
// the pointer advances only when a transaction completes.
module phs_rr_arbiter
  import phs_axil_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic [1:0] req,
  input  logic      done,
  input  port_idx_t done_port,
  output port_idx_t pick
);

  port_idx_t last_served;

  // Remember who finished last; reset value lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_served <= 1'b1;
    else if (done) last_served <= done_port;
  end

  // Combinational choice from the current request vector.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = ~last_served;
    else if (req[1])  pick = 1'b1;
  end

endmodule

// File: rtl/phs_axil_arbiter.sv
// Shares the PHS register slave between two AXI4-Lite masters, one complete
// transaction at a time. Arbitration costs one IDLE cycle; once granted, the
// owner's channels are wired straight through to the slave.
module phs_axil_arbiter
  import phs_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // Requester 0
  input  logic [ADDR_WIDTH-1:0]   S0_AXI_AWADDR,
  input  logic [2:0]              S0_AXI_AWPROT,
  input  logic                    S0_AXI_AWVALID,
  output logic                    S0_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S0_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S0_AXI_WSTRB,
  input  logic                    S0_AXI_WVALID,
  output logic                    S0_AXI_WREADY,
  output logic [1:0]              S0_AXI_BRESP,
  output logic                    S0_AXI_BVALID,
  input  logic                    S0_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S0_AXI_ARADDR,
  input  logic [2:0]              S0_AXI_ARPROT,
  input  logic                    S0_AXI_ARVALID,
  output logic                    S0_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S0_AXI_RDATA,
  output logic [1:0]              S0_AXI_RRESP,
  output logic                    S0_AXI_RVALID,
  input  logic                    S0_AXI_RREADY,
  // Requester 1
  input  logic [ADDR_WIDTH-1:0]   S1_AXI_AWADDR,
  input  logic [2:0]              S1_AXI_AWPROT,
  input  logic                    S1_AXI_AWVALID,
  output logic                    S1_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S1_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S1_AXI_WSTRB,
  input  logic                    S1_AXI_WVALID,
  output logic                    S1_AXI_WREADY,
  output logic [1:0]              S1_AXI_BRESP,
  output logic                    S1_AXI_BVALID,
  input  logic                    S1_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S1_AXI_ARADDR,
  input  logic [2:0]              S1_AXI_ARPROT,
  input  logic                    S1_AXI_ARVALID,
  output logic                    S1_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S1_AXI_RDATA,
  output logic [1:0]              S1_AXI_RRESP,
  output logic                    S1_AXI_RVALID,
  input  logic                    S1_AXI_RREADY,
  // To the PHS register slave
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  output logic [1:0]              GRANT,
  output logic                    BUSY
);

  state_t    state;
  port_idx_t gidx;
  port_idx_t pick;
  logic [1:0] grant_q;
  logic       busy_q;
  logic       aw_done, w_done;
  logic [1:0] wr_req, rd_req;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Owner-side responses before they are steered to one requester.
  logic                  aw_ready_g, w_ready_g, ar_ready_g, b_valid_g, r_valid_g;
  logic [1:0]            b_resp_g, r_resp_g;
  logic [DATA_WIDTH-1:0] r_data_g;

  assign wr_req = {S1_AXI_AWVALID | S1_AXI_WVALID, S0_AXI_AWVALID | S0_AXI_WVALID};
  assign rd_req = {S1_AXI_ARVALID, S0_AXI_ARVALID};

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID  & M_AXI_RREADY;

  phs_rr_arbiter u_rr (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req       (wr_req | rd_req),
    .done      (b_hs | r_hs),
    .done_port (gidx),
    .pick      (pick)
  );

  // Transaction sequencer: arbitrate in IDLE, then hold the grant to completion.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= ST_IDLE;
      gidx    <= 1'b0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (|(wr_req | rd_req)) begin
          gidx    <= pick;
          grant_q <= port_onehot(pick);
          busy_q  <= 1'b1;
          state   <= wr_req[pick] ? ST_WR_ADDR : ST_RD_ADDR;
        end
        ST_WR_ADDR: begin
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state   <= ST_WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        ST_WR_RESP: if (b_hs) begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        ST_RD_ADDR: if (ar_hs) state <= ST_RD_DATA;
        ST_RD_DATA: if (r_hs) begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign GRANT = grant_q;
  assign BUSY  = busy_q;

  // Wire the owner's channels to the slave for the phase currently active.
  always_comb begin
    M_AXI_AWADDR  = '0;
    M_AXI_AWPROT  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARPROT  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    aw_ready_g    = 1'b0;
    w_ready_g     = 1'b0;
    ar_ready_g    = 1'b0;
    b_valid_g     = 1'b0;
    r_valid_g     = 1'b0;
    b_resp_g      = '0;
    r_resp_g      = '0;
    r_data_g      = '0;
    case (state)
      ST_WR_ADDR: begin
        M_AXI_AWADDR  = gidx ? S1_AXI_AWADDR : S0_AXI_AWADDR;
        M_AXI_AWPROT  = gidx ? S1_AXI_AWPROT : S0_AXI_AWPROT;
        M_AXI_AWVALID = (gidx ? S1_AXI_AWVALID : S0_AXI_AWVALID) & ~aw_done;
        M_AXI_WDATA   = gidx ? S1_AXI_WDATA : S0_AXI_WDATA;
        M_AXI_WSTRB   = gidx ? S1_AXI_WSTRB : S0_AXI_WSTRB;
        M_AXI_WVALID  = (gidx ? S1_AXI_WVALID : S0_AXI_WVALID) & ~w_done;
        aw_ready_g    = M_AXI_AWREADY & ~aw_done;
        w_ready_g     = M_AXI_WREADY & ~w_done;
      end
      ST_WR_RESP: begin
        M_AXI_BREADY = gidx ? S1_AXI_BREADY : S0_AXI_BREADY;
        b_valid_g    = M_AXI_BVALID;
        b_resp_g     = M_AXI_BRESP;
      end
      ST_RD_ADDR: begin
        M_AXI_ARADDR  = gidx ? S1_AXI_ARADDR : S0_AXI_ARADDR;
        M_AXI_ARPROT  = gidx ? S1_AXI_ARPROT : S0_AXI_ARPROT;
        M_AXI_ARVALID = gidx ? S1_AXI_ARVALID : S0_AXI_ARVALID;
        ar_ready_g    = M_AXI_ARREADY;
      end
      ST_RD_DATA: begin
        M_AXI_RREADY = gidx ? S1_AXI_RREADY : S0_AXI_RREADY;
        r_valid_g    = M_AXI_RVALID;
        r_data_g     = M_AXI_RDATA;
        r_resp_g     = M_AXI_RRESP;
      end
      default: ;
    endcase
  end

  // Steer responses to the owner only; the other port sees all zeros.
  assign S0_AXI_AWREADY = aw_ready_g & ~gidx;
  assign S0_AXI_WREADY  = w_ready_g  & ~gidx;
  assign S0_AXI_BVALID  = b_valid_g  & ~gidx;
  assign S0_AXI_BRESP   = gidx ? 2'b00 : b_resp_g;
  assign S0_AXI_ARREADY = ar_ready_g & ~gidx;
  assign S0_AXI_RVALID  = r_valid_g  & ~gidx;
  assign S0_AXI_RDATA   = gidx ? '0 : r_data_g;
  assign S0_AXI_RRESP   = gidx ? 2'b00 : r_resp_g;

  assign S1_AXI_AWREADY = aw_ready_g & gidx;
  assign S1_AXI_WREADY  = w_ready_g  & gidx;
  assign S1_AXI_BVALID  = b_valid_g  & gidx;
  assign S1_AXI_BRESP   = gidx ? b_resp_g : 2'b00;
  assign S1_AXI_ARREADY = ar_ready_g & gidx;
  assign S1_AXI_RVALID  = r_valid_g  & gidx;
  assign S1_AXI_RDATA   = gidx ? r_data_g : '0;
  assign S1_AXI_RRESP   = gidx ? r_resp_g : 2'b00;

endmodule
